// File: rtl/grid_vga_render.sv
// 640x480 VGA timing generator that paints a 4x8 grid of 3-bit colour cells.
// The grid colours are captured once per frame so the picture never tears.
module grid_vga_render #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int GRID_X0  = 200,
  parameter int CELL     = 60
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic [23:0] column_0,
  input  logic [23:0] column_1,
  input  logic [23:0] column_2,
  input  logic [23:0] column_3,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int OW      = $clog2(CELL);

  logic              pix_en_q, pix_en_d;
  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic [OW-1:0]     x_off_q, x_off_d, y_off_q, y_off_d;
  logic [1:0]        col_q, col_d;
  logic [2:0]        row_q, row_d;
  logic [3:0][23:0]  fb_q, fb_d;
  logic              hs_q, hs_d, vs_q, vs_d;
  logic [2:0]        rgb_q, rgb_d;
  logic              h_wrap, v_wrap, snap, in_grid;
  logic [23:0]       cell_word;
  logic [2:0]        cell_rgb;

  function automatic logic [3:0] expand(input logic bit_in);
    return {4{bit_in}};
  endfunction

  always_comb begin
    pix_en_d = ~pix_en_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    x_off_d  = x_off_q;
    y_off_d  = y_off_q;
    col_d    = col_q;
    row_d    = row_q;
    fb_d     = fb_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    rgb_d    = rgb_q;

    h_wrap = (h_cnt_q == HW'(H_TOTAL - 1));
    v_wrap = (v_cnt_q == VW'(V_TOTAL - 1));
    snap   = pix_en_q && (h_cnt_q == '0) && (v_cnt_q == VW'(V_ACTIVE));

    in_grid = (h_cnt_q >= HW'(GRID_X0)) && (h_cnt_q < HW'(GRID_X0 + 4 * CELL)) &&
              (v_cnt_q < VW'(8 * CELL)) &&
              (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
    cell_word = fb_q[col_q];
    cell_rgb  = cell_word[5'd23 - 5'd3 * {2'b00, row_q} -: 3];

    if (pix_en_q) begin
      hs_d  = !((h_cnt_q >= HW'(H_ACTIVE + H_FP)) && (h_cnt_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
      vs_d  = !((v_cnt_q >= VW'(V_ACTIVE + V_FP)) && (v_cnt_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
      rgb_d = 3'b000;
      if (in_grid && (x_off_q != '0) && (y_off_q != '0)) begin
        rgb_d = cell_rgb;
      end

      h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
      end

      // Cell sub-counters track the coordinate the main counters are moving to.
      if (h_cnt_d == HW'(GRID_X0)) begin
        x_off_d = '0;
        col_d   = 2'd0;
      end else if (x_off_q == OW'(CELL - 1)) begin
        x_off_d = '0;
        col_d   = col_q + 2'd1;
      end else begin
        x_off_d = x_off_q + OW'(1);
      end

      if (h_wrap) begin
        if (v_cnt_d == '0) begin
          y_off_d = '0;
          row_d   = 3'd0;
        end else if (y_off_q == OW'(CELL - 1)) begin
          y_off_d = '0;
          row_d   = row_q + 3'd1;
        end else begin
          y_off_d = y_off_q + OW'(1);
        end
      end
    end

    if (snap) begin
      fb_d = {column_3, column_2, column_1, column_0};
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      pix_en_q <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      x_off_q  <= '0;
      y_off_q  <= '0;
      col_q    <= 2'd0;
      row_q    <= 3'd0;
      fb_q     <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      rgb_q    <= 3'b000;
    end else begin
      pix_en_q <= pix_en_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      x_off_q  <= x_off_d;
      y_off_q  <= y_off_d;
      col_q    <= col_d;
      row_q    <= row_d;
      fb_q     <= fb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      rgb_q    <= rgb_d;
    end
  end

  assign vga_hs     = hs_q;
  assign vga_vs     = vs_q;
  assign vga_r      = expand(rgb_q[2]);
  assign vga_g      = expand(rgb_q[1]);
  assign vga_b      = expand(rgb_q[0]);
  assign frame_tick = snap;

endmodule

// File: tb/tb_grid_vga_render.sv
// Scoreboarded bench for grid_vga_render on a shrunken raster so whole frames run quickly.
module tb_grid_vga_render;

  localparam int HA = 24, HFP = 2, HSY = 3, HBP = 3, HT = HA + HFP + HSY + HBP;
  localparam int VA = 34, VFP = 2, VSY = 2, VBP = 2, VT = VA + VFP + VSY + VBP;
  localparam int X0 = 6, C = 4;
  localparam int FR = 2 * HT * VT;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       tick;
  } exp_t;

  localparam exp_t RST_EXP = exp_t'({2'b11, 13'b0});

  logic        CLK_50M = 1'b0;
  logic        RST_N   = 1'b0;
  logic [23:0] column_0, column_1, column_2, column_3;
  logic        vga_hs, vga_vs, frame_tick;
  logic [3:0]  vga_r, vga_g, vga_b;
  exp_t        act_w;

  int nvec = 0;
  int nerr = 0;

  grid_vga_render #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .GRID_X0(X0), .CELL(C)
  ) dut (
    .CLK_50M(CLK_50M), .RST_N(RST_N),
    .column_0(column_0), .column_1(column_1), .column_2(column_2), .column_3(column_3),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_tick(frame_tick)
  );

  assign act_w = {vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_tick};

  always #10 CLK_50M = ~CLK_50M;

  // Reference model: derives raster position from the edge count since reset release.
  longint      e_cnt;
  logic [23:0] fb_m [4];
  exp_t        sbq [$];
  logic        sb_on = 1'b0;

  function automatic exp_t model_out(input longint e);
    exp_t x;
    longint p, q;
    int h, v, col, row;
    logic [23:0] w;
    x = RST_EXP;
    p = e / 2 - 1;
    if (p >= 0) begin
      h = int'(p % HT);
      v = int'((p / HT) % VT);
      x.hs = !(h >= HA + HFP && h < HA + HFP + HSY);
      x.vs = !(v >= VA + VFP && v < VA + VFP + VSY);
      if (h < HA && v < VA && h >= X0 && h < X0 + 4 * C && v < 8 * C &&
          (h - X0) % C != 0 && v % C != 0) begin
        col = (h - X0) / C;
        row = v / C;
        w = fb_m[col] >> (21 - 3 * row);
        x.r = {4{w[2]}};
        x.g = {4{w[1]}};
        x.b = {4{w[0]}};
      end
    end
    if (e % 2 == 1) begin
      q = (e - 1) / 2;
      x.tick = (q % HT == 0) && ((q / HT) % VT == VA);
    end
    return x;
  endfunction

  always @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      e_cnt = 0;
      foreach (fb_m[i]) fb_m[i] = 24'h0;
    end else begin
      longint p;
      e_cnt = e_cnt + 1;
      p = e_cnt / 2 - 1;
      if (e_cnt % 2 == 0 && p >= 0 && p % HT == 0 && (p / HT) % VT == VA) begin
        fb_m[0] = column_0;
        fb_m[1] = column_1;
        fb_m[2] = column_2;
        fb_m[3] = column_3;
      end
      if (sb_on) sbq.push_back(model_out(e_cnt));
    end
  end

  task automatic sb_pop(output exp_t ex);
    @(negedge CLK_50M);
    if (sbq.size() > 0) ex = sbq.pop_front();
    else ex = 'x;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    sb_on = 1'b0;
    column_0 = 24'hFFFFFF; column_1 = 24'hFFFFFF;
    column_2 = 24'hFFFFFF; column_3 = 24'hFFFFFF;
    repeat (3) @(negedge CLK_50M);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_50M);
      nvec++;
      if (act_w !== RST_EXP) begin
        nerr++;
        $display("FAIL reset_state cyc %0d: got %h want %h", i, act_w, RST_EXP);
      end
    end
  endtask

  task automatic test_timing;
    int NT;
    exp_t ex;
    logic prev_hs, prev_vs;
    int hs_first, hs_fall, hs_per, hs_low, vs_fall, vs_per, vs_low;
    NT = 2 * (HT * (VA + VFP) + 1) + FR + 20;
    prev_hs = 1'b1; prev_vs = 1'b1;
    hs_first = -1; hs_fall = -1; hs_per = -1; hs_low = -1;
    vs_fall = -1; vs_per = -1; vs_low = -1;
    @(negedge CLK_50M);
    RST_N = 1'b1;
    sb_on = 1'b1;
    for (int n = 1; n <= NT; n++) begin
      sb_pop(ex);
      nvec++;
      if (act_w !== ex) begin
        nerr++;
        $display("FAIL timing cyc %0d: got %h want %h", n, act_w, ex);
      end
      if (prev_hs && !vga_hs) begin
        if (hs_first < 0) hs_first = n;
        else hs_per = n - hs_fall;
        hs_fall = n;
      end
      if (!prev_hs && vga_hs && hs_fall > 0) hs_low = n - hs_fall;
      if (prev_vs && !vga_vs) begin
        if (vs_fall > 0) vs_per = n - vs_fall;
        vs_fall = n;
      end
      if (!prev_vs && vga_vs && vs_fall > 0) vs_low = n - vs_fall;
      prev_hs = vga_hs;
      prev_vs = vga_vs;
    end
    sb_on = 1'b0;
    nvec++;
    if (hs_first != 2 * (HA + HFP + 1)) begin
      nerr++; $display("FAIL hs_first_fall: got %0d want %0d", hs_first, 2 * (HA + HFP + 1));
    end
    nvec++;
    if (hs_per != 2 * HT) begin
      nerr++; $display("FAIL hs_period: got %0d want %0d", hs_per, 2 * HT);
    end
    nvec++;
    if (hs_low != 2 * HSY) begin
      nerr++; $display("FAIL hs_low: got %0d want %0d", hs_low, 2 * HSY);
    end
    nvec++;
    if (vs_per != FR) begin
      nerr++; $display("FAIL vs_period: got %0d want %0d", vs_per, FR);
    end
    nvec++;
    if (vs_low != 2 * HT * VSY) begin
      nerr++; $display("FAIL vs_low: got %0d want %0d", vs_low, 2 * HT * VSY);
    end
  endtask

  task automatic test_frame(input logic [23:0] c0, input logic [23:0] c1,
                            input logic [23:0] c2, input logic [23:0] c3,
                            input logic [11:0] rgb, input int exp_cnt, input string nm);
    exp_t ex;
    int k, cnt, t1, gap;
    k = 0; cnt = 0; t1 = 0; gap = -1;
    @(negedge CLK_50M);
    column_0 = c0; column_1 = c1; column_2 = c2; column_3 = c3;
    sb_on = 1'b1;
    for (int n = 1; n <= 2 * FR + 20 && k < 2; n++) begin
      sb_pop(ex);
      nvec++;
      if (act_w !== ex) begin
        nerr++;
        $display("FAIL %s cyc %0d: got %h want %h", nm, n, act_w, ex);
      end
      if (k == 1 && {vga_r, vga_g, vga_b} == rgb) cnt++;
      if (frame_tick === 1'b1) begin
        k++;
        if (k == 1) t1 = n;
        else gap = n - t1;
      end
    end
    sb_on = 1'b0;
    sbq.delete();
    nvec++;
    if (k != 2) begin
      nerr++; $display("FAIL %s_ticks: got %0d want 2", nm, k);
    end
    nvec++;
    if (cnt != exp_cnt) begin
      nerr++; $display("FAIL %s_colour_count: got %0d want %0d", nm, cnt, exp_cnt);
    end
    nvec++;
    if (gap != FR) begin
      nerr++; $display("FAIL %s_tick_gap: got %0d want %0d", nm, gap, FR);
    end
  endtask

  task automatic test_tear_free;
    exp_t ex;
    int k, t1, cnt1, cnt2;
    k = 0; t1 = 0; cnt1 = 0; cnt2 = 0;
    @(negedge CLK_50M);
    column_0 = 24'h0; column_1 = 24'h0; column_2 = 24'h0; column_3 = 24'h0;
    sb_on = 1'b1;
    for (int n = 1; n <= 3 * FR + 20 && k < 3; n++) begin
      sb_pop(ex);
      nvec++;
      if (act_w !== ex) begin
        nerr++;
        $display("FAIL tear_free cyc %0d: got %h want %h", n, act_w, ex);
      end
      if (k == 1 && n - t1 == 2 * HT * (VT - VA + 12)) column_1 = 24'h249249;
      if ({vga_r, vga_g, vga_b} == 12'h00F) begin
        if (k == 1) cnt1++;
        if (k == 2) cnt2++;
      end
      if (frame_tick === 1'b1) begin
        k++;
        if (k == 1) t1 = n;
      end
    end
    sb_on = 1'b0;
    sbq.delete();
    nvec++;
    if (k != 3) begin
      nerr++; $display("FAIL tear_ticks: got %0d want 3", k);
    end
    nvec++;
    if (cnt1 != 0) begin
      nerr++; $display("FAIL tear_same_frame: got %0d blue cycles want 0", cnt1);
    end
    nvec++;
    if (cnt2 != 8 * (C - 1) * (C - 1) * 2) begin
      nerr++; $display("FAIL tear_next_frame: got %0d want %0d", cnt2, 8 * (C - 1) * (C - 1) * 2);
    end
  endtask

  task automatic test_reset_midline;
    exp_t ex;
    logic found;
    found = 1'b0;
    @(negedge CLK_50M);
    sb_on = 1'b1;
    for (int n = 1; n <= FR + 20 && !found; n++) begin
      sb_pop(ex);
      nvec++;
      if (act_w !== ex) begin
        nerr++;
        $display("FAIL midline_run cyc %0d: got %h want %h", n, act_w, ex);
      end
      if ({vga_r, vga_g, vga_b} == 12'hFFF) found = 1'b1;
    end
    nvec++;
    if (!found) begin
      nerr++; $display("FAIL midline_white: got 0 want 1");
    end
    RST_N = 1'b0;
    sb_on = 1'b0;
    sbq.delete();
    #1;
    nvec++;
    if (act_w !== RST_EXP) begin
      nerr++; $display("FAIL midline_async: got %h want %h", act_w, RST_EXP);
    end
    repeat (3) @(negedge CLK_50M);
    nvec++;
    if (act_w !== RST_EXP) begin
      nerr++; $display("FAIL midline_held: got %h want %h", act_w, RST_EXP);
    end
    test_timing();
  endtask

  initial begin
    test_reset();
    test_timing();
    test_frame(24'hE00000, 24'h0, 24'h0, 24'h0, 12'hFFF, (C - 1) * (C - 1) * 2, "cell_fill");
    test_frame(24'h0, 24'h0, 24'h0, 24'h000004, 12'hF00, (C - 1) * (C - 1) * 2, "bottom_right");
    test_tear_free();
    test_frame(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 12'hFFF,
               32 * (C - 1) * (C - 1) * 2, "blanking");
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
